fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch buffer between instruction memory and IF/ID.
// Issues one word-addressed fetch per cycle while credits are available
// (count + outstanding < DEPTH), queues {pc, instruction} pairs in a small FIFO,
// and presents the head to IF/ID. A flush discards buffered and in-flight fetches
// and restarts fetching at redirect_pc.
// Optional build macro FETCH_BUFFER_BYPASS_EN: a response arriving into an empty
// buffer is presented combinationally the same cycle and, if accepted, never
// enters the FIFO.
module fetch_buffer #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [INST_WIDTH-1:0] mem_data,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    // out_q marks a live request whose response arrives next cycle. Flush and
    // reset clear it (no request issues during flush), so any response to a
    // pre-flush request is squashed by simply not matching a live request.
    logic                  out_q, out_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

    logic [INST_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];

    logic                  credit_s;
    logic                  resp_ok_s;
    logic                  head_s;
    logic                  byp_s;
    logic                  pop_s;
    logic                  fifo_pop_s;
    logic                  push_s;

    // Credit check for a new fetch and acceptance of a live response
    always_comb begin
        credit_s  = ((count_q + CNT_W'(out_q)) < DEPTH_C);
        mem_req   = ~reset & credit_s & ~flush;
        mem_addr  = fetch_pc_q;
        resp_ok_s = mem_valid & out_q & ~flush;
    end

    // Head selection (FIFO head first, else optional same-cycle bypass) and push/pop
    always_comb begin
        head_s = (count_q != {CNT_W{1'b0}});
`ifdef FETCH_BUFFER_BYPASS_EN
        byp_s  = resp_ok_s & ~head_s;
`else
        byp_s  = 1'b0;
`endif
        if (head_s) begin
            inst_valid  = 1'b1;
            instruction = data_q[rd_ptr_q];
            inst_pc     = pc_q[rd_ptr_q];
        end else if (byp_s) begin
            inst_valid  = 1'b1;
            instruction = mem_data;
            inst_pc     = out_addr_q;
        end else begin
            inst_valid  = 1'b0;
            instruction = {INST_WIDTH{1'b0}};
            inst_pc     = {ADDR_WIDTH{1'b0}};
        end
        pop_s      = inst_valid & ~stall & ~flush;
        fifo_pop_s = pop_s & head_s;
        // A bypassed response that is consumed this cycle never enters the FIFO
        push_s     = resp_ok_s & ~(byp_s & pop_s);
    end

    // Next-state for fetch PC, FIFO occupancy/pointers and the in-flight tracker
    always_comb begin
        if (flush) begin
            fetch_pc_d = redirect_pc;
            count_d    = {CNT_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
        end else begin
            if (mem_req) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1'b1);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(fifo_pop_s);
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (fifo_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
        out_d = mem_req;
        if (mem_req) begin
            out_addr_d = fetch_pc_q;
        end else begin
            out_addr_d = out_addr_q;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            out_q      <= 1'b0;
            out_addr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_q      <= out_d;
            out_addr_q <= out_addr_d;
        end
    end

    // FIFO storage: write the returned instruction and its fetch address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= {INST_WIDTH{1'b0}};
                pc_q[i]   <= {ADDR_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            data_q[wr_ptr_q] <= mem_data;
            pc_q[wr_ptr_q]   <= out_addr_q;
        end
    end

endmodule
